// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel debouncer with a shared run-time stability
// threshold and a configurable reset level.
// Each channel has a synchroniser, a 4-state hysteresis FSM with a check
// counter, a registered debounced level, and single-cycle rise/fall strobes.
// Optional sticky event flags and an interrupt line are enabled with the
// macro DEBOUNCE_MULTI_EVENT_EN.
// Debug outputs: o_dbg_state packs the 2-bit FSM state of every channel and
// o_dbg_cnt packs every check counter (channel c at [c*W +: W]).
module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_LEVEL = 0
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic [CHANNELS-1:0]       i_sig,
  input  logic [WIDTH-1:0]          i_limit,
`ifdef DEBOUNCE_MULTI_EVENT_EN
  input  logic [CHANNELS-1:0]       i_evt_clr,
  output logic [CHANNELS-1:0]       o_evt,
  output logic                      o_irq,
`endif
  output logic [CHANNELS-1:0]       o_deb,
  output logic [CHANNELS-1:0]       o_rise,
  output logic [CHANNELS-1:0]       o_fall,
  output logic                      o_any,
  output logic [2*CHANNELS-1:0]     o_dbg_state,
  output logic [CHANNELS*WIDTH-1:0] o_dbg_cnt
);

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  localparam logic   RST_LVL   = (RESET_LEVEL != 0);
  localparam state_t RST_STATE = RST_LVL ? S_HI : S_LO;

  // Debounced level implied by each channel's next FSM state.
  logic [CHANNELS-1:0] deb_d;
  logic [CHANNELS-1:0] deb_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic                any_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH-1:0]       cnt_q;
    logic [WIDTH-1:0]       cnt_d;

    // Synchroniser chain; resets to the configured level so release is quiet.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) sync_q <= {SYNC_STAGES{RST_LVL}};
      else           sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig[c]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // FSM state and check-counter registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        state_q <= RST_STATE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Hysteresis next-state: the new level must hold until cnt reaches the
    // threshold; any reversion aborts. The >= compare makes a lowered
    // threshold commit immediately and keeps the counter from wrapping.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        S_LO: begin
          if (s) state_d = S_CHK_HI;
        end
        S_CHK_HI: begin
          if (!s)                  state_d = S_LO;
          else if (cnt_q >= i_limit) state_d = S_HI;
          else                     cnt_d   = cnt_q + 1'b1;
        end
        S_HI: begin
          if (!s) state_d = S_CHK_LO;
        end
        S_CHK_LO: begin
          if (s)                   state_d = S_HI;
          else if (cnt_q >= i_limit) state_d = S_LO;
          else                     cnt_d   = cnt_q + 1'b1;
        end
        default: begin
          state_d = RST_STATE;
        end
      endcase
    end

    assign deb_d[c]                    = (state_d == S_HI) || (state_d == S_CHK_LO);
    assign o_dbg_state[2*c +: 2]       = state_q;
    assign o_dbg_cnt[WIDTH*c +: WIDTH] = cnt_q;
  end

  // Registered level and strobes; strobes mark the first cycle of a new level.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      deb_q  <= {CHANNELS{RST_LVL}};
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      deb_q  <= deb_d;
      rise_q <= deb_d & ~deb_q;
      fall_q <= ~deb_d & deb_q;
      any_q  <= |(deb_d ^ deb_q);
    end
  end

  assign o_deb  = deb_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_any  = any_q;

`ifdef DEBOUNCE_MULTI_EVENT_EN
  logic [CHANNELS-1:0] evt_q;
  logic                irq_q;

  // Sticky event flags (set beats clear) and an interrupt that follows them.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= (evt_q & ~i_evt_clr) | rise_q | fall_q;
      irq_q <= |evt_q;
    end
  end

  assign o_evt = evt_q;
  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (CHANNELS=4, WIDTH=8, SYNC_STAGES=2,
// RESET_LEVEL=0). Edges are counted from the first posedge after an input
// change; outputs are sampled 1 time unit after each posedge.
module tb_debounce_multi;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sig;
  logic [7:0]  limit;
  logic [3:0]  deb;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic        any_o;
  logic [7:0]  dbg_state;
  logic [31:0] dbg_cnt;
`ifdef DEBOUNCE_MULTI_EVENT_EN
  logic [3:0]  evt_clr;
  logic [3:0]  evt;
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .RESET_LEVEL(0)
  ) dut (
    .i_clk       (clk),
    .i_arst_n    (rst_n),
    .i_sig       (sig),
    .i_limit     (limit),
`ifdef DEBOUNCE_MULTI_EVENT_EN
    .i_evt_clr   (evt_clr),
    .o_evt       (evt),
    .o_irq       (irq),
`endif
    .o_deb       (deb),
    .o_rise      (rise),
    .o_fall      (fall),
    .o_any       (any_o),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sig   = 4'hF;
    limit = 8'd3;
`ifdef DEBOUNCE_MULTI_EVENT_EN
    evt_clr = 4'h0;
`endif
    #22;
    check("rst_deb",   64'(deb),       64'h0);
    check("rst_rise",  64'(rise),      64'h0);
    check("rst_fall",  64'(fall),      64'h0);
    check("rst_any",   64'(any_o),     64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_cnt",   64'(dbg_cnt),   64'h0);
`ifdef DEBOUNCE_MULTI_EVENT_EN
    check("rst_evt",   64'(evt),       64'h0);
    check("rst_irq",   64'(irq),       64'h0);
`endif

    // Release with all inputs high, limit 3: commit at edge 6.
    @(negedge clk);
    rst_n = 1'b1;
    steps(1);
    check("rel_deb",  64'(deb),  64'h0);
    check("rel_rise", 64'(rise), 64'h0);
    check("rel_any",  64'(any_o), 64'h0);
    steps(5);
    check("e5_deb",    64'(deb),            64'h0);
    check("e5_cnt0",   64'(dbg_cnt[7:0]),   64'd3);
    check("e5_state0", 64'(dbg_state[1:0]), 64'd1);
    steps(1);
    check("e6_deb",    64'(deb),            64'hF);
    check("e6_rise",   64'(rise),           64'hF);
    check("e6_any",    64'(any_o),          64'h1);
    check("e6_state0", 64'(dbg_state[1:0]), 64'd2);
    check("e6_cnt0",   64'(dbg_cnt[7:0]),   64'd0);
    steps(1);
    check("e7_rise", 64'(rise),  64'h0);
    check("e7_any",  64'(any_o), 64'h0);
    check("e7_deb",  64'(deb),   64'hF);

    // All low with limit 0: fall at edge 3.
    sig   = 4'h0;
    limit = 8'd0;
    steps(3);
    check("fall_e2_deb", 64'(deb),  64'hF);
    check("fall_e2_fall", 64'(fall), 64'h0);
    steps(1);
    check("fall_e3_deb",  64'(deb),   64'h0);
    check("fall_e3_fall", 64'(fall),  64'hF);
    check("fall_e3_any",  64'(any_o), 64'h1);
    steps(1);
    check("fall_e4_fall", 64'(fall), 64'h0);

    // Glitch: ch1 high for 4 cycles with limit 5 never commits.
    limit = 8'd5;
    sig   = 4'b0010;
    steps(4);
    sig   = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      steps(1);
      check("glitch_deb", 64'(deb),   64'h0);
      check("glitch_any", 64'(any_o), 64'h0);
    end
    check("glitch_state1", 64'(dbg_state[3:2]), 64'd0);
    check("glitch_cnt1",   64'(dbg_cnt[15:8]),  64'd0);

    // ch2 with limit 0: rise at edge 3, then fall at edge 3.
    limit = 8'd0;
    sig   = 4'b0100;
    steps(3);
    check("ch2_e2_deb", 64'(deb), 64'h0);
    steps(1);
    check("ch2_e3_deb",  64'(deb),   64'b0100);
    check("ch2_e3_rise", 64'(rise),  64'b0100);
    check("ch2_e3_any",  64'(any_o), 64'h1);
    steps(1);
    check("ch2_e4_rise", 64'(rise), 64'h0);
    sig = 4'b0000;
    steps(3);
    check("ch2f_e2_deb", 64'(deb), 64'b0100);
    steps(1);
    check("ch2f_e3_deb",  64'(deb),   64'h0);
    check("ch2f_e3_fall", 64'(fall),  64'b0100);
    check("ch2f_e3_any",  64'(any_o), 64'h1);
    steps(1);
    check("ch2f_e4_fall", 64'(fall),  64'h0);
    check("ch2f_e4_any",  64'(any_o), 64'h0);

    // ch0 and ch3 together with limit 2: commit at edge 5.
    limit = 8'd2;
    sig   = 4'b1001;
    steps(5);
    check("dual_e4_deb", 64'(deb), 64'h0);
    steps(1);
    check("dual_e5_deb",  64'(deb),   64'b1001);
    check("dual_e5_rise", 64'(rise),  64'b1001);
    check("dual_e5_any",  64'(any_o), 64'h1);
    steps(1);
    check("dual_e6_rise", 64'(rise),  64'h0);
    check("dual_e6_any",  64'(any_o), 64'h0);

`ifdef DEBOUNCE_MULTI_EVENT_EN
    // Clear everything, then ch1 rise sets evt[1]; irq follows a cycle later.
    evt_clr = 4'hF;
    steps(1);
    evt_clr = 4'h0;
    check("evt_clr_all", 64'(evt), 64'h0);
    steps(1);
    check("irq_clr_all", 64'(irq), 64'h0);
    limit = 8'd0;
    sig   = 4'b1011;
    steps(4);
    check("evt_rise1",    64'(rise), 64'b0010);
    check("evt_before",   64'(evt),  64'h0);
    steps(1);
    check("evt_set1",     64'(evt),  64'b0010);
    check("irq_lag",      64'(irq),  64'h0);
    steps(1);
    check("irq_set",      64'(irq),  64'h1);
    // Clear coincides with a new ch1 fall strobe: set wins.
    sig = 4'b1001;
    steps(4);
    check("evt_fall1", 64'(fall), 64'b0010);
    evt_clr = 4'b0010;
    steps(1);
    evt_clr = 4'h0;
    check("evt_set_wins", 64'(evt), 64'b0010);
    steps(1);
    check("evt_sticky", 64'(evt), 64'b0010);
    evt_clr = 4'b0010;
    steps(1);
    evt_clr = 4'h0;
    check("evt_cleared", 64'(evt), 64'h0);
    check("irq_still",   64'(irq), 64'h1);
    steps(1);
    check("irq_cleared", 64'(irq), 64'h0);
`endif

    // Threshold lowered mid-check on ch1: commit on the next edge.
    limit = 8'd200;
    sig   = 4'b1011;
    steps(53);
    check("lim_cnt50",  64'(dbg_cnt[15:8]),  64'd50);
    check("lim_state1", 64'(dbg_state[3:2]), 64'd1);
    check("lim_deb",    64'(deb),            64'b1001);
    limit = 8'd10;
    steps(1);
    check("lim_commit_deb", 64'(deb),            64'b1011);
    check("lim_commit_rise", 64'(rise),          64'b0010);
    check("lim_commit_any", 64'(any_o),          64'h1);
    check("lim_cnt0",       64'(dbg_cnt[15:8]),  64'd0);
    check("lim_state_hi",   64'(dbg_state[3:2]), 64'd2);

    // Reset asserted mid-check on ch2: immediate, and silent on release.
    sig = 4'b1111;
    steps(4);
    check("mid_state2", 64'(dbg_state[5:4]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_deb",    64'(deb),       64'h0);
    check("mid_rst_state",  64'(dbg_state), 64'h0);
    check("mid_rst_cnt",    64'(dbg_cnt),   64'h0);
    check("mid_rst_any",    64'(any_o),     64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(1);
    check("mid_rel_rise", 64'(rise),  64'h0);
    check("mid_rel_fall", 64'(fall),  64'h0);
    check("mid_rel_any",  64'(any_o), 64'h0);
    check("mid_rel_deb",  64'(deb),   64'h0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
